// File: rtl/clock_pkg.sv
// Shared encodings for the seg_clock timekeeper: set-mode field codes and field limits.
// Latency: n/a (constants and a pure function only).
// Backpressure: none.
package clock_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;
    localparam logic [1:0] ST_SET_SEC  = 2'd3;

    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;
    localparam int HOUR_W     = 5;
    localparam int MINSEC_W   = 6;

    // key_mode walks RUN -> HOUR -> MIN -> SEC -> RUN
    function automatic logic [1:0] next_field(input logic [1:0] st);
        logic [1:0] nxt;
        case (st)
            ST_RUN:      nxt = ST_SET_HOUR;
            ST_SET_HOUR: nxt = ST_SET_MIN;
            ST_SET_MIN:  nxt = ST_SET_SEC;
            default:     nxt = ST_RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up-counter with combinational carry on wrap; used for sec/min/hour.
// Latency: value updates on the edge that samples inc; carry is same-cycle.
// Backpressure: none; every inc pulse is consumed.
module mod_counter #(
    parameter int MAX  = 59,
    parameter int W    = 6,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         carry
);

    logic at_max;

    assign at_max = (value == W'(MAX));
    assign carry  = inc && at_max;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= W'(INIT);
        end else if (inc) begin
            value <= at_max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/clock_timekeeper.sv
// Hour/min/sec timekeeper with 1 Hz prescaler, free-running scan strobe and key-driven set mode.
// Latency: time, tick_1hz and set_field update on the edge that samples the cause; all outputs registered.
// Backpressure: none; key pulses act on the cycle they arrive, key_mode wins over key_inc.
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_DIV  = 50_000,
    parameter int INIT_HOUR = 22,
    parameter int INIT_MIN  = 46,
    parameter int INIT_SEC  = 40
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                key_mode,
    input  logic                key_inc,
    output logic [HOUR_W-1:0]   hour,
    output logic [MINSEC_W-1:0] min,
    output logic [MINSEC_W-1:0] sec,
    output logic                tick_1hz,
    output logic                scan_tick,
    output logic [1:0]          set_field
);

    localparam int PW = (CLK_HZ   > 1) ? $clog2(CLK_HZ)   : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [SW-1:0] scan_cnt;

    logic run;
    logic presc_tc;
    logic tick_now;
    logic edit_inc;
    logic scan_tc;
    logic sec_inc, min_inc, hour_inc;
    logic sec_carry, min_carry;

    assign run      = (state == ST_RUN);
    assign presc_tc = (presc == PW'(CLK_HZ - 1));
    assign tick_now = run && presc_tc;
    assign edit_inc = key_inc && !key_mode;
    assign scan_tc  = (scan_cnt == SW'(SCAN_DIV - 1));

    // In RUN carries ripple sec->min->hour; in SET only the edited field moves.
    assign sec_inc  = tick_now || ((state == ST_SET_SEC) && edit_inc);
    assign min_inc  = run ? sec_carry : ((state == ST_SET_MIN)  && edit_inc);
    assign hour_inc = run ? min_carry : ((state == ST_SET_HOUR) && edit_inc);

    assign set_field = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RUN;
        end else if (key_mode) begin
            state <= next_field(state);
        end
    end

    // Held at 0 while editing so leaving SET_SEC gives a full second before the next tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc    <= '0;
            tick_1hz <= 1'b0;
        end else begin
            tick_1hz <= tick_now;
            if (!run || presc_tc) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= scan_tc;
            scan_cnt  <= scan_tc ? '0 : scan_cnt + SW'(1);
        end
    end

    mod_counter #(
        .MAX  (MINSEC_MAX),
        .W    (MINSEC_W),
        .INIT (INIT_SEC)
    ) u_sec (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (sec_inc),
        .value (sec),
        .carry (sec_carry)
    );

    mod_counter #(
        .MAX  (MINSEC_MAX),
        .W    (MINSEC_W),
        .INIT (INIT_MIN)
    ) u_min (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (min_inc),
        .value (min),
        .carry (min_carry)
    );

    mod_counter #(
        .MAX  (HOUR_MAX),
        .W    (HOUR_W),
        .INIT (INIT_HOUR)
    ) u_hour (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (hour_inc),
        .value (hour),
        .carry ()
    );

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper at CLK_HZ=10, SCAN_DIV=4.
module tb_clock_timekeeper;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       tick_1hz;
    logic       scan_tick;
    logic [1:0] set_field;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    clock_timekeeper #(
        .CLK_HZ    (10),
        .SCAN_DIV  (4),
        .INIT_HOUR (22),
        .INIT_MIN  (46),
        .INIT_SEC  (40)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .tick_1hz  (tick_1hz),
        .scan_tick (scan_tick),
        .set_field (set_field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hour"}, 32'(hour), h);
        chk({tag, ".min"},  32'(min),  m);
        chk({tag, ".sec"},  32'(sec),  s);
    endtask

    // One clock; scan_tick must be high exactly on every 4th edge since reset release.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("scan_tick", 32'(scan_tick), (cyc % 4 == 0) ? 1 : 0);
    endtask

    task automatic press_mode();
        key_mode = 1'b1;
        step();
        key_mode = 1'b0;
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            key_inc = 1'b1;
            step();
            key_inc = 1'b0;
            chk("tick_in_set", 32'(tick_1hz), 0);
        end
    endtask

    // Nine quiet cycles, then the tick on the tenth.
    task automatic run_to_tick(input string tag);
        for (int i = 1; i < 10; i++) begin
            step();
            chk({tag, ".tick_early"}, 32'(tick_1hz), 0);
        end
        step();
        chk({tag, ".tick"}, 32'(tick_1hz), 1);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_time("reset", 22, 46, 40);
        chk("reset.set_field", 32'(set_field), 0);
        chk("reset.tick", 32'(tick_1hz), 0);
        chk("reset.scan", 32'(scan_tick), 0);
        rstn = 1'b1;
        cyc  = 0;

        // first tick on cycle 10
        for (int i = 1; i < 10; i++) begin
            step();
            chk("first.tick_early", 32'(tick_1hz), 0);
        end
        chk_time("before_first", 22, 46, 40);
        step();
        chk("first.tick", 32'(tick_1hz), 1);
        chk_time("first", 22, 46, 41);
        step();
        chk("first.tick_pulse", 32'(tick_1hz), 0);

        // key_inc in RUN is ignored
        key_inc = 1'b1;
        step();
        key_inc = 1'b0;
        chk_time("run_inc", 22, 46, 41);

        // SET_HOUR: 22 -> 23 -> 0 -> 1, others frozen
        press_mode();
        chk("set_hour.field", 32'(set_field), 1);
        press_inc(1);
        chk_time("hour_23", 23, 46, 41);
        press_inc(1);
        chk_time("hour_0", 0, 46, 41);
        press_inc(1);
        chk_time("hour_1", 1, 46, 41);
        repeat (12) step();
        chk_time("set_frozen", 1, 46, 41);
        chk("set_frozen.field", 32'(set_field), 1);
        press_inc(22);
        chk_time("hour_23b", 23, 46, 41);

        // SET_MIN to 59, then key_mode+key_inc together
        press_mode();
        chk("set_min.field", 32'(set_field), 2);
        press_inc(13);
        chk_time("min_59", 23, 59, 41);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        step();
        key_mode = 1'b0;
        key_inc  = 1'b0;
        chk("both.field", 32'(set_field), 3);
        chk_time("both", 23, 59, 41);

        // SET_SEC: wrap without carry
        press_inc(18);
        chk_time("sec_59", 23, 59, 59);
        press_inc(1);
        chk_time("sec_wrap_nocarry", 23, 59, 0);
        press_inc(59);
        chk_time("sec_59b", 23, 59, 59);

        // back to RUN: full carry 23:59:59 -> 00:00:00 ten cycles later
        press_mode();
        chk("run.field", 32'(set_field), 0);
        run_to_tick("midnight");
        chk_time("midnight", 0, 0, 0);

        // 22:59:59 -> 23:00:00
        press_mode();
        press_inc(22);
        press_mode();
        press_inc(59);
        press_mode();
        press_inc(59);
        chk_time("pre_hour_carry", 22, 59, 59);
        press_mode();
        chk("hc.field", 32'(set_field), 0);
        run_to_tick("hour_carry");
        chk_time("hour_carry", 23, 0, 0);

        // 22:46:59 -> 22:47:00
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(46);
        press_mode();
        press_inc(59);
        chk_time("pre_min_carry", 22, 46, 59);
        press_mode();
        run_to_tick("min_carry");
        chk_time("min_carry", 22, 47, 0);

        // async reset while editing minutes
        press_mode();
        press_mode();
        chk("pre_rst.field", 32'(set_field), 2);
        press_inc(3);
        chk_time("pre_rst", 22, 50, 0);
        rstn = 1'b0;
        #2;
        chk_time("mid_rst", 22, 46, 40);
        chk("mid_rst.field", 32'(set_field), 0);
        chk("mid_rst.tick", 32'(tick_1hz), 0);
        chk("mid_rst.scan", 32'(scan_tick), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc  = 0;
        run_to_tick("after_rst");
        chk_time("after_rst", 22, 46, 41);
        chk("after_rst.field", 32'(set_field), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
